// File: rtl/traffic_pkg.sv
// Shared lane geometry, small typedefs and the emergency FSM state encoding
// for the traffic sensor conditioner.
package traffic_pkg;

  localparam int NUM_LANES   = 4;
  localparam int IR_PER_LANE = 3;
  localparam int IR_W        = NUM_LANES * IR_PER_LANE;

  typedef logic [1:0] lane_idx_t;
  typedef logic [1:0] density_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } emerg_state_t;

  function automatic density_t lane_popcount(input logic [IR_PER_LANE-1:0] bits);
    density_t cnt;
    cnt = '0;
    for (int i = 0; i < IR_PER_LANE; i++) begin
      cnt = cnt + density_t'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One IR bit: two-flop synchroniser followed by a stable-count debounce that
// only lets the clean output follow after DEBOUNCE_CYCLES consecutive disagreements.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic clean_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          clean_q;
  logic          clean_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The count clears on the edge it would reach the limit, so it never wraps.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (sync2_q != clean_q) begin
      if (cnt_q >= CNT_LAST) begin
        clean_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean_o = clean_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Sensor front-end: debounced IR bits, per-lane density, and emergency lock FSM.
//   state   | meaning
//   IDLE    | no emergency; pick lowest-index high sound lane as candidate
//   QUALIFY | candidate must stay high EMERG_HOLD_CYCLES edges
//   ACTIVE  | emergency granted while candidate stays high
//   RELEASE | grant held until candidate low EMERG_RELEASE_CYCLES edges
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 4,
  parameter int HEAVY_THRESHOLD      = 2,
  parameter int EMERG_HOLD_CYCLES    = 8,
  parameter int EMERG_RELEASE_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [IR_W-1:0]        ir_raw_i,
  input  logic [NUM_LANES-1:0]   sound_raw_i,
  output logic [IR_W-1:0]        ir_clean_o,
  output logic [NUM_LANES-1:0]   sound_clean_o,
  output logic [2*NUM_LANES-1:0] lane_density_o,
  output logic [NUM_LANES-1:0]   heavy_lanes_o,
  output logic                   emergency_valid_o,
  output logic [1:0]             emergency_lane_o
);

  localparam int EMAX = (EMERG_RELEASE_CYCLES > EMERG_HOLD_CYCLES) ?
                        EMERG_RELEASE_CYCLES : EMERG_HOLD_CYCLES;
  localparam int ECW  = $clog2(EMAX + 1);
  localparam logic [ECW-1:0] HOLD_LAST    = ECW'(EMERG_HOLD_CYCLES - 1);
  localparam logic [ECW-1:0] RELEASE_LAST = ECW'(EMERG_RELEASE_CYCLES - 1);
  localparam density_t       HEAVY_T      = density_t'(HEAVY_THRESHOLD);

  logic [IR_W-1:0] ir_clean;

  for (genvar b = 0; b < IR_W; b++) begin : g_ir
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .raw_i   (ir_raw_i[b]),
      .clean_o (ir_clean[b])
    );
  end

  logic [2*NUM_LANES-1:0] density_q;
  logic [2*NUM_LANES-1:0] density_d;
  logic [NUM_LANES-1:0]   heavy_q;
  logic [NUM_LANES-1:0]   heavy_d;

  // Heavy flags come from the same popcount so they land with the density.
  always_comb begin
    density_d = '0;
    heavy_d   = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      density_d[2*l +: 2] = lane_popcount(ir_clean[IR_PER_LANE*l +: IR_PER_LANE]);
      heavy_d[l]          = lane_popcount(ir_clean[IR_PER_LANE*l +: IR_PER_LANE]) >= HEAVY_T;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      density_q <= '0;
      heavy_q   <= '0;
    end else begin
      density_q <= density_d;
      heavy_q   <= heavy_d;
    end
  end

  logic [NUM_LANES-1:0] snd_s1_q;
  logic [NUM_LANES-1:0] snd_s2_q;
  emerg_state_t         state_q;
  emerg_state_t         state_d;
  logic [ECW-1:0]       cnt_q;
  logic [ECW-1:0]       cnt_d;
  lane_idx_t            cand_q;
  lane_idx_t            cand_d;
  lane_idx_t            pick_lane;
  logic                 cand_bit;
  logic                 valid_q;
  logic                 valid_d;
  lane_idx_t            lane_q;
  lane_idx_t            lane_d;
  logic [NUM_LANES-1:0] sclean_q;
  logic [NUM_LANES-1:0] sclean_d;

  always_comb begin
    pick_lane = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (snd_s2_q[l]) begin
        pick_lane = lane_idx_t'(l);
      end
    end
  end

  assign cand_bit = snd_s2_q[cand_q];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      snd_s1_q <= '0;
      snd_s2_q <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      valid_q  <= 1'b0;
      lane_q   <= '0;
      sclean_q <= '0;
    end else begin
      snd_s1_q <= sound_raw_i;
      snd_s2_q <= snd_s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      valid_q  <= valid_d;
      lane_q   <= lane_d;
      sclean_q <= sclean_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    case (state_q)
      IDLE: begin
        if (|snd_s2_q) begin
          cand_d  = pick_lane;
          cnt_d   = ECW'(1);
          state_d = QUALIFY;
        end
      end
      QUALIFY: begin
        if (!cand_bit) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q >= HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACTIVE: begin
        if (!cand_bit) begin
          cnt_d   = ECW'(1);
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (cand_bit) begin
          cnt_d   = '0;
          state_d = ACTIVE;
        end else if (cnt_q >= RELEASE_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the FSM.
  always_comb begin
    valid_d  = (state_d == ACTIVE) || (state_d == RELEASE);
    lane_d   = '0;
    sclean_d = '0;
    if (valid_d) begin
      lane_d           = cand_d;
      sclean_d[cand_d] = 1'b1;
    end
  end

  assign ir_clean_o        = ir_clean;
  assign lane_density_o    = density_q;
  assign heavy_lanes_o     = heavy_q;
  assign emergency_valid_o = valid_q;
  assign emergency_lane_o  = lane_q;
  assign sound_clean_o     = sclean_q;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner: reset, IR debounce, density,
// emergency qualify/lock/release, re-entry and reset mid-grant.
module tb_traffic_sensor_conditioner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] ir_raw;
  logic [3:0]  sound_raw;
  logic [11:0] ir_clean;
  logic [3:0]  sound_clean;
  logic [7:0]  lane_density;
  logic [3:0]  heavy_lanes;
  logic        emergency_valid;
  logic [1:0]  emergency_lane;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_sensor_conditioner dut (
    .clk_i             (clk),
    .reset_i           (rst_n),
    .ir_raw_i          (ir_raw),
    .sound_raw_i       (sound_raw),
    .ir_clean_o        (ir_clean),
    .sound_clean_o     (sound_clean),
    .lane_density_o    (lane_density),
    .heavy_lanes_o     (heavy_lanes),
    .emergency_valid_o (emergency_valid),
    .emergency_lane_o  (emergency_lane)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ir_raw = 12'hFFF; sound_raw = 4'hF;
    step(3);
    checks++;
    if ({ir_clean, lane_density, heavy_lanes} !== 24'h0) begin
      errors++; $display("FAIL reset_ir: got %h expected %h", {ir_clean, lane_density, heavy_lanes}, 24'h0);
    end
    checks++;
    if ({emergency_valid, emergency_lane, sound_clean} !== 7'h0) begin
      errors++; $display("FAIL reset_emerg: got %h expected %h", {emergency_valid, emergency_lane, sound_clean}, 7'h0);
    end
    sound_raw = 4'h0; rst_n = 1'b1;
    step(5);
    checks++;
    if (ir_clean !== 12'h000) begin
      errors++; $display("FAIL reset_ir_early: got %h expected %h", ir_clean, 12'h000);
    end
    step(1);
    checks++;
    if ({ir_clean, lane_density} !== {12'hFFF, 8'h00}) begin
      errors++; $display("FAIL reset_ir_edge6: got %h expected %h", {ir_clean, lane_density}, {12'hFFF, 8'h00});
    end
    step(1);
    checks++;
    if ({lane_density, heavy_lanes} !== {8'hFF, 4'hF}) begin
      errors++; $display("FAIL reset_density: got %h expected %h", {lane_density, heavy_lanes}, {8'hFF, 4'hF});
    end
    ir_raw = 12'h000;
    step(8);
    checks++;
    if ({ir_clean, lane_density, heavy_lanes} !== 24'h0) begin
      errors++; $display("FAIL ir_fall: got %h expected %h", {ir_clean, lane_density, heavy_lanes}, 24'h0);
    end
  endtask

  task automatic test_glitch();
    ir_raw = 12'h010;
    step(3);
    ir_raw = 12'h000;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if ({ir_clean, lane_density} !== 20'h0) begin
        errors++; $display("FAIL glitch_reject[%0d]: got %h expected %h", i, {ir_clean, lane_density}, 20'h0);
      end
    end
    ir_raw = 12'h010;
    step(5);
    checks++;
    if (ir_clean !== 12'h000) begin
      errors++; $display("FAIL pulse_early: got %h expected %h", ir_clean, 12'h000);
    end
    step(1);
    checks++;
    if (ir_clean !== 12'h010) begin
      errors++; $display("FAIL pulse_clean: got %h expected %h", ir_clean, 12'h010);
    end
    step(1);
    checks++;
    if ({lane_density, heavy_lanes} !== {8'h04, 4'h0}) begin
      errors++; $display("FAIL pulse_density: got %h expected %h", {lane_density, heavy_lanes}, {8'h04, 4'h0});
    end
    step(3);
    ir_raw = 12'h000;
    step(8);
    checks++;
    if ({ir_clean, lane_density} !== 20'h0) begin
      errors++; $display("FAIL pulse_fall: got %h expected %h", {ir_clean, lane_density}, 20'h0);
    end
  endtask

  task automatic test_density();
    ir_raw = 12'h137;
    step(7);
    checks++;
    if ({ir_clean, lane_density, heavy_lanes} !== {12'h137, 8'h1B, 4'b0011}) begin
      errors++; $display("FAIL density_137: got %h expected %h", {ir_clean, lane_density, heavy_lanes}, {12'h137, 8'h1B, 4'b0011});
    end
    ir_raw = 12'hFC0;
    step(7);
    checks++;
    if ({ir_clean, lane_density, heavy_lanes} !== {12'hFC0, 8'hF0, 4'b1100}) begin
      errors++; $display("FAIL density_FC0: got %h expected %h", {ir_clean, lane_density, heavy_lanes}, {12'hFC0, 8'hF0, 4'b1100});
    end
    ir_raw = 12'h000;
    step(8);
  endtask

  task automatic test_emergency();
    sound_raw = 4'b0001;
    step(9);
    checks++;
    if (emergency_valid !== 1'b0) begin
      errors++; $display("FAIL qualify_early: got %b expected %b", emergency_valid, 1'b0);
    end
    step(1);
    checks++;
    if ({emergency_valid, emergency_lane, sound_clean} !== {1'b1, 2'd0, 4'b0001}) begin
      errors++; $display("FAIL qualify_grant: got %h expected %h", {emergency_valid, emergency_lane, sound_clean}, {1'b1, 2'd0, 4'b0001});
    end
    sound_raw = 4'b0000;
    step(17);
    checks++;
    if (emergency_valid !== 1'b1) begin
      errors++; $display("FAIL release_hold: got %b expected %b", emergency_valid, 1'b1);
    end
    step(1);
    checks++;
    if ({emergency_valid, sound_clean} !== 5'h0) begin
      errors++; $display("FAIL release_end: got %h expected %h", {emergency_valid, sound_clean}, 5'h0);
    end
    sound_raw = 4'b0001;
    step(5);
    sound_raw = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if (emergency_valid !== 1'b0) begin
        errors++; $display("FAIL short_pulse[%0d]: got %b expected %b", i, emergency_valid, 1'b0);
      end
    end
  endtask

  task automatic test_priority_lock();
    sound_raw = 4'b0100;
    step(10);
    checks++;
    if ({emergency_valid, emergency_lane, sound_clean} !== {1'b1, 2'd2, 4'b0100}) begin
      errors++; $display("FAIL lane2_grant: got %h expected %h", {emergency_valid, emergency_lane, sound_clean}, {1'b1, 2'd2, 4'b0100});
    end
    sound_raw = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      step(1);
      checks++;
      if ({emergency_valid, emergency_lane, sound_clean} !== {1'b1, 2'd2, 4'b0100}) begin
        errors++; $display("FAIL lock[%0d]: got %h expected %h", i, {emergency_valid, emergency_lane, sound_clean}, {1'b1, 2'd2, 4'b0100});
      end
    end
    sound_raw = 4'b0001;
    for (int i = 0; i < 17; i++) begin
      step(1);
      checks++;
      if ({emergency_valid, emergency_lane} !== {1'b1, 2'd2}) begin
        errors++; $display("FAIL lock_release[%0d]: got %h expected %h", i, {emergency_valid, emergency_lane}, {1'b1, 2'd2});
      end
    end
    step(1);
    checks++;
    if (emergency_valid !== 1'b0) begin
      errors++; $display("FAIL lock_release_end: got %b expected %b", emergency_valid, 1'b0);
    end
    step(7);
    checks++;
    if (emergency_valid !== 1'b0) begin
      errors++; $display("FAIL lane0_early: got %b expected %b", emergency_valid, 1'b0);
    end
    step(1);
    checks++;
    if ({emergency_valid, emergency_lane, sound_clean} !== {1'b1, 2'd0, 4'b0001}) begin
      errors++; $display("FAIL lane0_grant: got %h expected %h", {emergency_valid, emergency_lane, sound_clean}, {1'b1, 2'd0, 4'b0001});
    end
  endtask

  task automatic test_reentry_reset();
    ir_raw = 12'h137;
    sound_raw = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if (emergency_valid !== 1'b1) begin
        errors++; $display("FAIL reentry_drop[%0d]: got %b expected %b", i, emergency_valid, 1'b1);
      end
    end
    sound_raw = 4'b0001;
    for (int i = 0; i < 30; i++) begin
      step(1);
      checks++;
      if ({emergency_valid, emergency_lane, sound_clean} !== {1'b1, 2'd0, 4'b0001}) begin
        errors++; $display("FAIL reentry_hold[%0d]: got %h expected %h", i, {emergency_valid, emergency_lane, sound_clean}, {1'b1, 2'd0, 4'b0001});
      end
    end
    checks++;
    if ({ir_clean, lane_density} !== {12'h137, 8'h1B}) begin
      errors++; $display("FAIL pre_reset_ir: got %h expected %h", {ir_clean, lane_density}, {12'h137, 8'h1B});
    end
    rst_n = 1'b0;
    step(1);
    checks++;
    if ({ir_clean, lane_density, heavy_lanes, emergency_valid, emergency_lane, sound_clean} !== 31'h0) begin
      errors++; $display("FAIL midgrant_reset: got %h expected %h", {ir_clean, lane_density, heavy_lanes, emergency_valid, emergency_lane, sound_clean}, 31'h0);
    end
    rst_n = 1'b1;
    step(9);
    checks++;
    if (emergency_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_early: got %b expected %b", emergency_valid, 1'b0);
    end
    step(1);
    checks++;
    if ({emergency_valid, emergency_lane, sound_clean} !== {1'b1, 2'd0, 4'b0001}) begin
      errors++; $display("FAIL post_reset_grant: got %h expected %h", {emergency_valid, emergency_lane, sound_clean}, {1'b1, 2'd0, 4'b0001});
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_density();
    test_emergency();
    test_priority_lock();
    test_reentry_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
